// File: rtl/player_action_encoder.sv
// Per-player button front end: debounce, per-tick latch, priority resolve and attack cooldown.
// Optional ACTION_ENC_JUMP_LOCK_EN forbids a JUMP on the tick right after an issued JUMP.
module player_action_encoder #(
    parameter int DEB_CYCLES = 3,
    parameter int TICK_DIV   = 4,
    parameter int COOLDOWN   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    output logic       tick,
    output logic [5:0] action_out,
    output logic       conflict,
    output logic [1:0] cooldown
);

    localparam int DCW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
    localparam int TCW = $clog2(TICK_DIV);
    localparam int CCW = $clog2(COOLDOWN + 1) + 2;

    localparam int B_R     = 5;
    localparam int B_L     = 4;
    localparam int B_JUMP  = 2;
    localparam int B_KICK  = 1;
    localparam int B_PUNCH = 0;

    localparam logic [5:0] ACT_R     = 6'b100000;
    localparam logic [5:0] ACT_L     = 6'b010000;
    localparam logic [5:0] ACT_WAIT  = 6'b001000;
    localparam logic [5:0] ACT_JUMP  = 6'b000100;
    localparam logic [5:0] ACT_KICK  = 6'b000010;
    localparam logic [5:0] ACT_PUNCH = 6'b000001;

    logic [5:0]     deb;
    logic [DCW-1:0] deb_cnt [6];
    logic [5:0]     stick;
    logic [TCW-1:0] tick_cnt;
    logic [CCW-1:0] cool_cnt;
    logic [5:0]     req;
    logic [5:0]     avail;
    logic [5:0]     next_action;
    logic           multi_req;
`ifdef ACTION_ENC_JUMP_LOCK_EN
    logic           jump_lock;
`endif

    // Raw buttons are sampled directly so raw->debounced latency stays exactly DEB_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (btn[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= btn[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            stick    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TCW'(1);
            stick    <= tick ? '0 : (stick | deb);
        end
    end

    // Conflict is judged on the raw request set, before any R/L, cooldown or lock drops.
    always_comb begin
        req       = stick | deb;
        multi_req = ($countones(req) > 1);
        avail     = req;
        if (req[B_R] && req[B_L]) begin
            avail[B_R] = 1'b0;
            avail[B_L] = 1'b0;
        end
        if (cool_cnt != '0) begin
            avail[B_KICK]  = 1'b0;
            avail[B_PUNCH] = 1'b0;
        end
`ifdef ACTION_ENC_JUMP_LOCK_EN
        if (jump_lock) avail[B_JUMP] = 1'b0;
`endif
        if (avail[B_JUMP])       next_action = ACT_JUMP;
        else if (avail[B_PUNCH]) next_action = ACT_PUNCH;
        else if (avail[B_KICK])  next_action = ACT_KICK;
        else if (avail[B_R])     next_action = ACT_R;
        else if (avail[B_L])     next_action = ACT_L;
        else                     next_action = ACT_WAIT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            action_out <= ACT_WAIT;
            conflict   <= 1'b0;
            cool_cnt   <= '0;
        end else if (tick) begin
            action_out <= next_action;
            conflict   <= multi_req;
            if (next_action[B_KICK] || next_action[B_PUNCH]) cool_cnt <= CCW'(COOLDOWN);
            else if (cool_cnt != '0)                         cool_cnt <= cool_cnt - CCW'(1);
        end
    end

`ifdef ACTION_ENC_JUMP_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst)       jump_lock <= 1'b0;
        else if (tick) jump_lock <= next_action[B_JUMP];
    end
`endif

    assign cooldown = (cool_cnt > CCW'(3)) ? 2'd3 : cool_cnt[1:0];

endmodule

// File: tb/tb_player_action_encoder.sv
// Self-checking bench for player_action_encoder: directed spec scenarios plus randomized buttons
// compared every cycle against a rule-level model (honours ACTION_ENC_JUMP_LOCK_EN).
module tb_player_action_encoder;

    localparam int DEB  = 3;
    localparam int TICK = 4;
    localparam int COOL = 2;

    localparam logic [5:0] A_R     = 6'b100000;
    localparam logic [5:0] A_L     = 6'b010000;
    localparam logic [5:0] A_WAIT  = 6'b001000;
    localparam logic [5:0] A_JUMP  = 6'b000100;
    localparam logic [5:0] A_KICK  = 6'b000010;
    localparam logic [5:0] A_PUNCH = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = '0;
    logic       tick;
    logic [5:0] action_out;
    logic       conflict;
    logic [1:0] cooldown;

    int testCount = 0;
    int failCount = 0;

    logic [5:0] mDeb;
    logic [5:0] mReq;
    logic [5:0] mAction;
    logic       mConflict;
    int         mCycle;
    int         mCool;
    logic [5:0] hist[$];
    int         prio[5] = '{2, 0, 1, 5, 4};
`ifdef ACTION_ENC_JUMP_LOCK_EN
    logic       mJlock;
`endif

    player_action_encoder #(
        .DEB_CYCLES(DEB),
        .TICK_DIV  (TICK),
        .COOLDOWN  (COOL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .tick      (tick),
        .action_out(action_out),
        .conflict  (conflict),
        .cooldown  (cooldown)
    );

    always #5 clk = ~clk;

    // Rule-level model: debounced level flips after DEB identical opposite samples,
    // requests accumulate over a tick period and are resolved at the period's last edge.
    task automatic modelEdge(input logic r, input logic [5:0] b);
        logic [5:0] req;
        logic [5:0] avail;
        int         pick;
        logic       flip;
        if (r) begin
            mDeb = '0; mReq = '0; mCycle = 0; mAction = A_WAIT; mConflict = 1'b0; mCool = 0;
            hist.delete();
`ifdef ACTION_ENC_JUMP_LOCK_EN
            mJlock = 1'b0;
`endif
        end else begin
            req = mReq | mDeb;
            if ((mCycle % TICK) == TICK - 1) begin
                mConflict = ($countones(req) > 1);
                avail = req;
                if (req[5] && req[4]) avail[5:4] = 2'b00;
                if (mCool != 0) avail[1:0] = 2'b00;
`ifdef ACTION_ENC_JUMP_LOCK_EN
                if (mJlock) avail[2] = 1'b0;
`endif
                pick = 3;
                for (int k = 4; k >= 0; k--) if (avail[prio[k]]) pick = prio[k];
                mAction = '0;
                mAction[pick] = 1'b1;
                if (pick == 0 || pick == 1) mCool = COOL;
                else if (mCool > 0) mCool--;
`ifdef ACTION_ENC_JUMP_LOCK_EN
                mJlock = (pick == 2);
`endif
                mReq = '0;
            end else begin
                mReq = req;
            end
            mCycle++;
            hist.push_back(b);
            if (hist.size() > DEB) void'(hist.pop_front());
            if (hist.size() == DEB) begin
                for (int i = 0; i < 6; i++) begin
                    flip = 1'b1;
                    for (int k = 0; k < DEB; k++) if (hist[k][i] == mDeb[i]) flip = 1'b0;
                    if (flip) mDeb[i] = ~mDeb[i];
                end
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compares every output against the model one time unit after the edge.
    task automatic checkOutput();
        checkVal("action", action_out, mAction);
        checkVal("conflict", {5'b0, conflict}, {5'b0, mConflict});
        checkVal("tick", {5'b0, tick}, {5'b0, ((mCycle % TICK) == TICK - 1)});
        checkVal("cooldown", {4'b0, cooldown}, 6'((mCool > 3) ? 3 : mCool));
        checkVal("onehot", {5'b0, $onehot(action_out)}, 6'b000001);
    endtask

    task automatic applyStimulus(input logic r, input logic [5:0] b);
        rst = r;
        btn = b;
        @(posedge clk);
        modelEdge(r, b);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b1, '0);
        applyStimulus(1'b1, '0);
    endtask

    task automatic holdCycles(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, b);
    endtask

    initial begin
        logic [5:0] seqAction[4];
        logic [5:0] seqCool[4];
        logic [5:0] cur;
        logic       r;

        // Reset values
        doReset();
        checkVal("reset_action", action_out, A_WAIT);
        checkVal("reset_conflict", {5'b0, conflict}, 6'd0);
        checkVal("reset_tick", {5'b0, tick}, 6'd0);
        checkVal("reset_cooldown", {4'b0, cooldown}, 6'd0);

        // Glitch shorter than debounce is ignored, a held press is taken
        doReset();
        applyStimulus(1'b0, A_PUNCH);
        holdCycles('0, 3);
        checkVal("glitch_wait", action_out, A_WAIT);
        holdCycles(A_PUNCH, 4);
        checkVal("held_punch", action_out, A_PUNCH);
        holdCycles(A_PUNCH, 1);
        checkVal("held_punch_stable", action_out, A_PUNCH);

        // Priority and conflict
        doReset();
        holdCycles(A_JUMP | A_KICK, 4);
        checkVal("jump_over_kick", action_out, A_JUMP);
        checkVal("jump_kick_conflict", {5'b0, conflict}, 6'd1);
        doReset();
        holdCycles(A_R | A_L, 4);
        checkVal("r_l_cancel", action_out, A_WAIT);
        checkVal("r_l_conflict", {5'b0, conflict}, 6'd1);

        // Attack cooldown
        seqAction = '{A_PUNCH, A_WAIT, A_WAIT, A_PUNCH};
        seqCool   = '{6'd2, 6'd1, 6'd0, 6'd2};
        doReset();
        for (int t = 0; t < 4; t++) begin
            holdCycles(A_PUNCH, 4);
            checkVal($sformatf("cool_action_%0d", t), action_out, seqAction[t]);
            checkVal($sformatf("cool_count_%0d", t), {4'b0, cooldown}, seqCool[t]);
        end

        // Short press latched across the tick boundary
        doReset();
        applyStimulus(1'b0, '0);
        holdCycles(A_KICK, 3);
        checkVal("latch_pre", action_out, A_WAIT);
        holdCycles('0, 4);
        checkVal("latch_kick", action_out, A_KICK);
        holdCycles('0, 4);
        checkVal("latch_after", action_out, A_WAIT);

        // Jump repetition with and without lock
        doReset();
        for (int t = 0; t < 3; t++) begin
            holdCycles(A_JUMP | A_R, 4);
`ifdef ACTION_ENC_JUMP_LOCK_EN
            checkVal($sformatf("jump_lock_%0d", t), action_out, (t == 1) ? A_R : A_JUMP);
`else
            checkVal($sformatf("jump_repeat_%0d", t), action_out, A_JUMP);
`endif
        end

        // Randomized buttons with glitches and occasional mid-tick reset
        doReset();
        cur = '0;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 3) == 0) cur = 6'($urandom);
            if ($urandom_range(0, 9) == 0) applyStimulus(r, cur ^ (6'd1 << $urandom_range(0, 5)));
            else applyStimulus(r, cur);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
